panel_io_bridge: RTL and testbench

//  Avalon-MM slave peripheral that owns the board front panel: NUM_HEX 7-seg digits, NUM_LED LEDs,
//  NUM_SW switches, NUM_BTN push buttons. Successor to the per-device PIO exports on the Nios system:
//  one parametrised block that adds hex decoding, digit blanking, switch synchronisation, button debounce,
//  and sticky press-event capture. Sits on the Nios data master; panel pins connect directly to its ports.

---
 rtl/panel_io_pkg.sv | 39 +++
 rtl/panel_io_bridge_hex7seg_dec.sv | 15 +
 rtl/panel_io_bridge.sv | 189 ++++++++++++++++++
 tb/tb_panel_io_bridge.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_io_pkg.sv
// Shared definitions for the front-panel Avalon-MM bridge: register map,
// active-low 7-segment glyphs and the per-button debounce record.
package panel_io_pkg;

  // Avalon word addresses of the panel registers
  localparam logic [2:0] REG_HEX_VAL   = 3'd0;
  localparam logic [2:0] REG_HEX_BLANK = 3'd1;
  localparam logic [2:0] REG_LED       = 3'd2;
  localparam logic [2:0] REG_SWITCH    = 3'd3;
  localparam logic [2:0] REG_BTN_STATE = 3'd4;
  localparam logic [2:0] REG_BTN_EDGE  = 3'd5;
  localparam logic [2:0] REG_IRQ_MASK  = 3'd6;

  // All segments off (segments are active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, segment a at bit 0; b and d are lowercase
  localparam logic [6:0] GLYPH_N [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Count field is sized for the largest supported debounce period; the
  // bridge only ever loads values below DEBOUNCE_CYC, so upper bits stay 0.
  localparam int unsigned DEB_CNT_W = 32;

  // Per-button debounce state: raw synchroniser pair, accepted level, timer
  typedef struct packed {
    logic [1:0]           sync;
    logic                 stable;
    logic [DEB_CNT_W-1:0] count;
  } btn_deb_t;

  // Glyph lookup with blanking
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib, input logic blank);
    return blank ? SEG_BLANK : GLYPH_N[nib];
  endfunction

endpackage

// File: rtl/panel_io_bridge_hex7seg_dec.sv
// Combinational nibble-to-7-segment decoder (active-low, seg a at bit 0).
module hex7seg_dec
  import panel_io_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_n_o
);

  // Glyph table lookup; a blanked digit drives every segment dark
  always_comb begin
    seg_n_o = seg_glyph(nibble_i, blank_i);
  end

endmodule

// File: rtl/panel_io_bridge.sv
// Front-panel Avalon-MM slave: 7-seg digits with blanking, LEDs, synchronised
// switches, debounced buttons with sticky press events.
// Optional feature macro: PANEL_IRQ_EN adds the irq port and IRQ_MASK register.
module panel_io_bridge
  import panel_io_pkg::*;
#(
  parameter int unsigned NUM_HEX      = 6,
  parameter int unsigned NUM_LED      = 10,
  parameter int unsigned NUM_SW       = 10,
  parameter int unsigned NUM_BTN      = 4,
  parameter int unsigned DEBOUNCE_CYC = 50000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  input  logic [NUM_BTN-1:0]   btn_n,
  input  logic [NUM_SW-1:0]    sw,
  output logic [NUM_LED-1:0]   led,
  output logic [NUM_HEX*7-1:0] hex_seg_n
`ifdef PANEL_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC);
  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYC - 1);

  logic [4*NUM_HEX-1:0] hex_val_q,   hex_val_d;
  logic [NUM_HEX-1:0]   hex_blank_q, hex_blank_d;
  logic [NUM_LED-1:0]   led_reg_q,   led_reg_d;
  logic [NUM_BTN-1:0]   btn_edge_q,  btn_edge_d;
  logic [31:0]          readdata_q,  readdata_d;
  logic [NUM_LED-1:0]   led_q;
  logic [NUM_HEX*7-1:0] hex_q;
  logic [NUM_HEX*7-1:0] seg_dec;
  logic [NUM_SW-1:0]    sw_meta_q, sw_sync_q;
  logic [NUM_BTN-1:0]   btn_stable;
  logic [NUM_BTN-1:0]   btn_rise;
  logic [31:0]          rd_mux;

  logic wr_hex_val, wr_hex_blank, wr_led, wr_btn_edge;

  // Only the low bits of writedata map to registers
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  assign wr_hex_val   = avs_write && (avs_address == REG_HEX_VAL);
  assign wr_hex_blank = avs_write && (avs_address == REG_HEX_BLANK);
  assign wr_led       = avs_write && (avs_address == REG_LED);
  assign wr_btn_edge  = avs_write && (avs_address == REG_BTN_EDGE);

`ifdef PANEL_IRQ_EN
  logic [NUM_BTN-1:0] irq_mask_q, irq_mask_d;
  logic               irq_q;
  logic               wr_irq_mask;

  assign wr_irq_mask = avs_write && (avs_address == REG_IRQ_MASK);
  assign irq         = irq_q;

  // Mask register next state
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_irq_mask) irq_mask_d = avs_writedata[NUM_BTN-1:0];
  end

  // Interrupt follows the registered edge bits, so it rises one cycle after them
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= |(btn_edge_q & irq_mask_q);
    end
  end
`endif

  // Per-button synchroniser and debounce timer
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_deb
    btn_deb_t   deb_q, deb_d;
    logic       pressed_sync;
    logic [CW-1:0] cnt_inc;

    assign pressed_sync  = ~deb_q.sync[1];
    assign cnt_inc       = deb_q.count[CW-1:0] + CW'(1);
    assign btn_stable[b] = deb_q.stable;
    assign btn_rise[b]   = deb_d.stable & ~deb_q.stable;

    // Accept a new level only after it has persisted for DEBOUNCE_CYC cycles
    always_comb begin
      deb_d      = deb_q;
      deb_d.sync = {deb_q.sync[0], btn_n[b]};
      if (pressed_sync == deb_q.stable) begin
        deb_d.count = '0;
      end else if (deb_q.count == CNT_LAST) begin
        deb_d.stable = pressed_sync;
        deb_d.count  = '0;
      end else begin
        deb_d.count = DEB_CNT_W'(cnt_inc);
      end
    end

    // Debounce state register; synchroniser resets to the released (high) level
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        deb_q.sync   <= 2'b11;
        deb_q.stable <= 1'b0;
        deb_q.count  <= '0;
      end else begin
        deb_q <= deb_d;
      end
    end
  end

  // Digit decoders feed the registered segment outputs
  for (genvar d = 0; d < NUM_HEX; d++) begin : g_hex
    hex7seg_dec u_dec (
      .nibble_i (hex_val_q[4*d +: 4]),
      .blank_i  (hex_blank_q[d]),
      .seg_n_o  (seg_dec[7*d +: 7])
    );
  end

  // Register-file next state, W1C on edge bits with a new edge taking priority
  always_comb begin
    hex_val_d   = hex_val_q;
    hex_blank_d = hex_blank_q;
    led_reg_d   = led_reg_q;
    btn_edge_d  = btn_edge_q;
    if (wr_hex_val)   hex_val_d   = avs_writedata[4*NUM_HEX-1:0];
    if (wr_hex_blank) hex_blank_d = avs_writedata[NUM_HEX-1:0];
    if (wr_led)       led_reg_d   = avs_writedata[NUM_LED-1:0];
    if (wr_btn_edge)  btn_edge_d  = btn_edge_d & ~avs_writedata[NUM_BTN-1:0];
    btn_edge_d = btn_edge_d | btn_rise;
  end

  // Read mux; unimplemented bits and addresses return 0
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      REG_HEX_VAL:   rd_mux[4*NUM_HEX-1:0] = hex_val_q;
      REG_HEX_BLANK: rd_mux[NUM_HEX-1:0]   = hex_blank_q;
      REG_LED:       rd_mux[NUM_LED-1:0]   = led_reg_q;
      REG_SWITCH:    rd_mux[NUM_SW-1:0]    = sw_sync_q;
      REG_BTN_STATE: rd_mux[NUM_BTN-1:0]   = btn_stable;
      REG_BTN_EDGE:  rd_mux[NUM_BTN-1:0]   = btn_edge_q;
`ifdef PANEL_IRQ_EN
      REG_IRQ_MASK:  rd_mux[NUM_BTN-1:0]   = irq_mask_q;
`endif
      default:       rd_mux = '0;
    endcase
    readdata_d = avs_read ? rd_mux : readdata_q;
  end

  // Registers, switch synchroniser and registered panel outputs
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hex_val_q   <= '0;
      hex_blank_q <= '1;
      led_reg_q   <= '0;
      btn_edge_q  <= '0;
      readdata_q  <= '0;
      led_q       <= '0;
      hex_q       <= '1;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
    end else begin
      hex_val_q   <= hex_val_d;
      hex_blank_q <= hex_blank_d;
      led_reg_q   <= led_reg_d;
      btn_edge_q  <= btn_edge_d;
      readdata_q  <= readdata_d;
      led_q       <= led_reg_q;
      hex_q       <= seg_dec;
      sw_meta_q   <= sw;
      sw_sync_q   <= sw_meta_q;
    end
  end

  assign avs_readdata = readdata_q;
  assign led          = led_q;
  assign hex_seg_n    = hex_q;

endmodule

// File: tb/tb_panel_io_bridge.sv
// Scoreboard bench for panel_io_bridge with a register-level reference model.
module tb_panel_io_bridge;

  localparam int NUM_HEX = 6;
  localparam int NUM_LED = 10;
  localparam int NUM_SW  = 10;
  localparam int NUM_BTN = 4;
  localparam int DEB     = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [2:0]           addr = '0;
  logic                 rd = 1'b0;
  logic                 wr = 1'b0;
  logic [31:0]          wdata = '0;
  logic [31:0]          rdata;
  logic [NUM_BTN-1:0]   btn_n = '1;
  logic [NUM_SW-1:0]    sw = '0;
  logic [NUM_LED-1:0]   led;
  logic [NUM_HEX*7-1:0] hex_seg_n;
`ifdef PANEL_IRQ_EN
  logic                 irq;
`endif

  panel_io_bridge #(
    .NUM_HEX(NUM_HEX), .NUM_LED(NUM_LED), .NUM_SW(NUM_SW),
    .NUM_BTN(NUM_BTN), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .avs_address   (addr),
    .avs_read      (rd),
    .avs_write     (wr),
    .avs_writedata (wdata),
    .avs_readdata  (rdata),
    .btn_n         (btn_n),
    .sw            (sw),
    .led           (led),
    .hex_seg_n     (hex_seg_n)
`ifdef PANEL_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef enum {K_RDATA, K_LED, K_HEX, K_IRQ} kind_e;
  typedef struct { logic [31:0] exp; string name; } rd_item_t;
  typedef struct { kind_e kind; logic [63:0] exp; string name; } out_item_t;

  rd_item_t  rd_q[$];
  out_item_t out_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit fin = 1'b0;

  // Reference model state (register view)
  logic [31:0] m_hex;
  logic [NUM_HEX-1:0] m_blank;
  logic [NUM_LED-1:0] m_led;
  logic [NUM_BTN-1:0] m_edge, m_state, m_mask;
  logic [NUM_SW-1:0]  m_sw;

  // Active-high gfedcba patterns of the standard hex glyphs
  function automatic logic [6:0] seg_hi(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [63:0] exp_hex();
    logic [63:0] r = '0;
    for (int d = 0; d < NUM_HEX; d++)
      r[7*d +: 7] = m_blank[d] ? 7'h7F : ~seg_hi(m_hex[4*d +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    logic [31:0] r = '0;
    case (a)
      3'd0: r = m_hex;
      3'd1: r[NUM_HEX-1:0] = m_blank;
      3'd2: r[NUM_LED-1:0] = m_led;
      3'd3: r[NUM_SW-1:0]  = m_sw;
      3'd4: r[NUM_BTN-1:0] = m_state;
      3'd5: r[NUM_BTN-1:0] = m_edge;
`ifdef PANEL_IRQ_EN
      3'd6: r[NUM_BTN-1:0] = m_mask;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_hex = '0; m_blank = '1; m_led = '0; m_edge = '0; m_state = '0; m_mask = '0;
  endtask

  // All bus tasks start and end on a falling edge
  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    case (a)
      3'd0: m_hex   = d & 32'h00FF_FFFF;
      3'd1: m_blank = d[NUM_HEX-1:0];
      3'd2: m_led   = d[NUM_LED-1:0];
      3'd5: m_edge  = m_edge & ~d[NUM_BTN-1:0];
`ifdef PANEL_IRQ_EN
      3'd6: m_mask  = d[NUM_BTN-1:0];
`endif
      default: ;
    endcase
  endtask

  task automatic do_read(input logic [2:0] a, input string nm);
    rd_item_t it;
    it.exp = model_rd(a); it.name = nm;
    rd_q.push_back(it);
    addr = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic push_out(input kind_e k, input logic [63:0] e, input string nm);
    out_item_t it;
    it.kind = k; it.exp = e; it.name = nm;
    out_q.push_back(it);
  endtask

  task automatic chk_out(input string nm);
    push_out(K_LED, 64'(m_led), {nm, "_led"});
    push_out(K_HEX, exp_hex(), {nm, "_hex"});
    @(negedge clk);
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: sole owner of the comparison counters
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic fired;
    out_item_t oi;
    rd_item_t  ri;
    fired = rd && !rst;
    #1;
    if (fired) begin
      if (rd_q.size() == 0) check("rd_unexpected", 64'(rdata), 64'hDEAD);
      else begin
        ri = rd_q.pop_front();
        check(ri.name, 64'(rdata), 64'(ri.exp));
      end
    end
    while (out_q.size() > 0) begin
      oi = out_q.pop_front();
      case (oi.kind)
        K_RDATA: check(oi.name, 64'(rdata), oi.exp);
        K_LED:   check(oi.name, 64'(led), oi.exp);
        K_HEX:   check(oi.name, 64'(hex_seg_n), oi.exp);
`ifdef PANEL_IRQ_EN
        K_IRQ:   check(oi.name, 64'(irq), oi.exp);
`endif
        default: check("bad_kind", 64'(oi.kind), 64'(K_RDATA));
      endcase
    end
    if (fin) begin
      check("rd_q_drained", 64'(rd_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [2:0]  a;
    int b, len;
    bit lng;
    model_reset();
    m_sw = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // Reset state
    push_out(K_RDATA, 64'd0, "reset_rdata");
    chk_out("reset");
    do_read(3'd0, "reset_hexval");
    do_read(3'd1, "reset_blank");

    // Directed display checks
    do_write(3'd0, 32'h00AB_CDEF);
    do_write(3'd1, 32'h0);
    @(negedge clk);
    chk_out("hex_abcdef");
    do_write(3'd1, 32'h2);
    @(negedge clk);
    chk_out("hex_blank1");
    do_write(3'd2, 32'h2A5);
    @(negedge clk);
    chk_out("led_2a5");
    do_read(3'd7, "addr7");

    // Randomised register traffic
    for (int i = 0; i < 40; i++) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      case ($urandom_range(0, 2))
        0: begin
          do_write(a, d);
          @(negedge clk);
          chk_out("rnd_out");
        end
        1: do_read(a, "rnd_rd");
        default: begin
          sw = NUM_SW'($urandom);
          m_sw = sw;
          repeat (3) @(negedge clk);
          do_read(3'd3, "rnd_sw");
        end
      endcase
    end

    // Short glitch on button 0 is ignored
    btn_n[0] = 1'b0;
    repeat (5) @(negedge clk);
    btn_n[0] = 1'b1;
    repeat (12) @(negedge clk);
    do_read(3'd4, "glitch_state");
    do_read(3'd5, "glitch_edge");

    // Long press on button 2
    btn_n[2] = 1'b0;
    repeat (20) @(negedge clk);
    m_state[2] = 1'b1; m_edge[2] = 1'b1;
    do_read(3'd4, "press2_state");
    do_read(3'd5, "press2_edge");
    btn_n[2] = 1'b1;
    repeat (14) @(negedge clk);
    m_state[2] = 1'b0;
    do_read(3'd4, "release2_state");
    do_read(3'd5, "release2_edge_sticky");
    do_write(3'd5, 32'h4);
    do_read(3'd5, "w1c_clear");

    // New edge coincides with W1C: set wins
    btn_n[2] = 1'b0;
    repeat (9) @(negedge clk);
    do_write(3'd5, 32'h4);
    m_edge[2] = 1'b1; m_state[2] = 1'b1;
    do_read(3'd5, "set_wins");
    do_read(3'd4, "set_wins_state");
    do_write(3'd5, 32'h4);
    do_read(3'd5, "w1c_after");
    btn_n[2] = 1'b1;
    repeat (14) @(negedge clk);
    m_state[2] = 1'b0;

    // Randomised button presses
    for (int i = 0; i < 8; i++) begin
      b   = $urandom_range(0, NUM_BTN - 1);
      lng = 1'($urandom_range(0, 1));
      len = lng ? $urandom_range(13, 20) : $urandom_range(1, 5);
      btn_n[b] = 1'b0;
      repeat (len) @(negedge clk);
      if (lng) begin
        m_state[b] = 1'b1; m_edge[b] = 1'b1;
        do_read(3'd4, "rnd_btn_held");
      end
      btn_n[b] = 1'b1;
      repeat (14) @(negedge clk);
      m_state[b] = 1'b0;
      do_read(3'd4, "rnd_btn_state");
      do_read(3'd5, "rnd_btn_edge");
      if ($urandom_range(0, 1) == 1) do_write(3'd5, $urandom);
    end

`ifdef PANEL_IRQ_EN
    do_write(3'd5, 32'hF);
    do_write(3'd6, 32'h1);
    do_read(3'd6, "irq_mask_rd");
    btn_n[0] = 1'b0;
    repeat (14) @(negedge clk);
    m_state[0] = 1'b1; m_edge[0] = 1'b1;
    push_out(K_IRQ, 64'd1, "irq_set");
    @(negedge clk);
    do_write(3'd5, 32'h1);
    @(negedge clk);
    push_out(K_IRQ, 64'd0, "irq_clear");
    @(negedge clk);
    btn_n[0] = 1'b1;
    repeat (14) @(negedge clk);
    m_state[0] = 1'b0;
`endif

    // Reset mid-debounce and with a captured edge pending
    do_write(3'd2, 32'h3FF);
    btn_n[1] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    btn_n[1] = 1'b1;
    do_reset(2);
    push_out(K_RDATA, 64'd0, "rst_rdata");
`ifdef PANEL_IRQ_EN
    push_out(K_IRQ, 64'd0, "rst_irq");
`endif
    chk_out("rst_mid");
    btn_n[3] = 1'b0;
    repeat (14) @(negedge clk);
    btn_n[3] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    btn_n[3] = 1'b1;
    do_reset(2);
    repeat (14) @(negedge clk);
    do_read(3'd5, "rst_edge_lost");
    do_read(3'd4, "rst_state");
    do_read(3'd2, "rst_led_reg");
    chk_out("rst_final");

    fin = 1'b1;
    repeat (10) @(negedge clk);
    $display("FAIL summary_not_reached: monitor did not finish");
    $fatal(1, "bench did not finish");
  end

endmodule
